// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions: FSM state encoding and the check-edge offset
// used by the FSM and by data_sampling.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    ERR_CHK = 3'd5
  } rx_state_e;

  // Checks fire two edges past mid-bit, once the mid-bit samples have settled.
  localparam int CHK_OFS = 2;

  function automatic int chk_edge(input int presc);
    return presc / 2 + CHK_OFS;
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter, data bit counter and PRESCALE latch for the UART RX FSM.
module uart_rx_edge_bit_cnt #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [PRESC_W-1:0] PRESCALE,
  input  logic               start,
  input  logic               run,
  input  logic               bit_clr,
  input  logic               bit_inc,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic               bit_end,
  output logic               chk_pre,
  output logic               last_bit
);
  import uart_rx_pkg::*;

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [PRESC_W-1:0] presc_q;
  logic [BW-1:0]      bit_cnt;

  assign bit_end  = (edge_cnt == presc_q - 1'b1);
  // One edge early so the registered enables land exactly on the check edge.
  assign chk_pre  = (int'(edge_cnt) == chk_edge(int'(presc_q)) - 1);
  assign last_bit = (bit_cnt == BW'(DATA_WIDTH - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      presc_q  <= '0;
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (start) begin
        presc_q  <= PRESCALE;
        edge_cnt <= PRESC_W'(1);
      end else if (run) begin
        edge_cnt <= bit_end ? '0 : edge_cnt + 1'b1;
      end else begin
        edge_cnt <= '0;
      end
      if (bit_clr)      bit_cnt <= '0;
      else if (bit_inc) bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART RX frame controller: start, data, optional parity, stop, error check.
// Define UART_RX_ERR_FLAGS_EN to add the par_err_flag / stp_err_flag outputs.
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic               PAR_EN,
  input  logic [PRESC_W-1:0] PRESCALE,
  input  logic               strt_glitch,
  input  logic               par_err,
  input  logic               stp_err,
  output logic               dat_samp_en,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic               strt_chk_en,
  output logic               deser_en,
  output logic               par_chk_en,
  output logic               stp_chk_en,
  output logic               data_valid
`ifdef UART_RX_ERR_FLAGS_EN
  ,
  output logic               par_err_flag,
  output logic               stp_err_flag
`endif
);
  import uart_rx_pkg::*;

  rx_state_e state;
  logic      start, run, bit_end, chk_pre, last_bit;
  logic      par_q;

  assign run         = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
  assign start       = ((state == IDLE) || (state == ERR_CHK)) && !RX_IN;
  assign dat_samp_en = run;

  uart_rx_edge_bit_cnt #(.DATA_WIDTH(DATA_WIDTH), .PRESC_W(PRESC_W)) u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .PRESCALE (PRESCALE),
    .start    (start),
    .run      (run),
    .bit_clr  ((state == START) && bit_end),
    .bit_inc  ((state == DATA) && bit_end),
    .edge_cnt (edge_cnt),
    .bit_end  (bit_end),
    .chk_pre  (chk_pre),
    .last_bit (last_bit)
  );

  // Decoded from ERR_CHK so checker results are read in that cycle only.
  assign data_valid = (state == ERR_CHK) && !stp_err && !(par_q && par_err);
`ifdef UART_RX_ERR_FLAGS_EN
  assign par_err_flag = (state == ERR_CHK) && par_q && par_err;
  assign stp_err_flag = (state == ERR_CHK) && stp_err;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      par_q       <= 1'b0;
      strt_chk_en <= 1'b0;
      deser_en    <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
    end else begin
      strt_chk_en <= (state == START)  && chk_pre;
      deser_en    <= (state == DATA)   && chk_pre;
      par_chk_en  <= (state == PARITY) && chk_pre;
      stp_chk_en  <= (state == STOP)   && chk_pre;
      case (state)
        IDLE:    if (!RX_IN) state <= START;
        START:   if (bit_end) state <= strt_glitch ? IDLE : DATA;
        DATA: begin
          if (bit_end && last_bit) begin
            par_q <= PAR_EN;
            state <= PAR_EN ? PARITY : STOP;
          end
        end
        PARITY:  if (bit_end) state <= STOP;
        STOP:    if (bit_end) state <= ERR_CHK;
        ERR_CHK: state <= RX_IN ? IDLE : START;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm at DATA_WIDTH=8; cycle t is the CLK period ending
// at the edge that samples the t-th line value (t=0: first low sample in IDLE).
module tb_uart_rx_fsm;

  logic       CLK = 1'b0;
  logic       RST, RX_IN, PAR_EN;
  logic [5:0] PRESCALE;
  logic       strt_glitch, par_err, stp_err;
  logic       dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid;
  logic [5:0] edge_cnt;
`ifdef UART_RX_ERR_FLAGS_EN
  logic       par_err_flag, stp_err_flag;
  logic [199:0] v_pef, v_sef;
`endif

  logic [199:0] v_deser, v_dv, v_strt, v_par, v_stp, v_samp, e;
  logic [5:0]   v_edge [200];
  int errors = 0;
  int checks = 0;

  uart_rx_fsm #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .PRESCALE    (PRESCALE),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .dat_samp_en (dat_samp_en),
    .edge_cnt    (edge_cnt),
    .strt_chk_en (strt_chk_en),
    .deser_en    (deser_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid)
`ifdef UART_RX_ERR_FLAGS_EN
    ,
    .par_err_flag(par_err_flag),
    .stp_err_flag(stp_err_flag)
`endif
  );

  always #5 CLK = ~CLK;

  // Drives the line bit-by-bit (or a short glitch) and records every output per cycle.
  task automatic run(input int ncyc, input logic [23:0] fb, input int nbits, input int presc_t,
                     input int glitch, input int chg_t, input int rst_t);
    PRESCALE = 6'(presc_t);
    repeat (3) begin @(negedge CLK); RX_IN = 1'b1; end
    v_deser = '0; v_dv = '0; v_strt = '0; v_par = '0; v_stp = '0; v_samp = '0;
`ifdef UART_RX_ERR_FLAGS_EN
    v_pef = '0; v_sef = '0;
`endif
    for (int t = 0; t < ncyc; t++) begin
      @(negedge CLK);
      if (glitch > 0)           RX_IN = (t >= glitch);
      else if (t >= rst_t)      RX_IN = 1'b1;
      else if (t / presc_t < nbits) RX_IN = fb[t / presc_t];
      else                      RX_IN = 1'b1;
      if (t == chg_t) PRESCALE = 6'd16;
      if (t == rst_t) RST = 1'b0;
      if (t == rst_t + 2) RST = 1'b1;
      #1;
      v_deser[t] = deser_en;   v_dv[t]  = data_valid;  v_strt[t] = strt_chk_en;
      v_par[t]   = par_chk_en; v_stp[t] = stp_chk_en;  v_samp[t] = dat_samp_en;
      v_edge[t]  = edge_cnt;
`ifdef UART_RX_ERR_FLAGS_EN
      v_pef[t] = par_err_flag; v_sef[t] = stp_err_flag;
`endif
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; RX_IN = 1'b0; PAR_EN = 1'b0; PRESCALE = 6'd8;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({edge_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", {edge_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid});
    end
    RX_IN = 1'b1;
    @(negedge CLK); RST = 1'b1;
  endtask

  task automatic test_clean_frame();
    run(90, {14'd0, 1'b1, 8'hA5, 1'b0}, 10, 8, 0, -1, 1 << 30);
    e = '0; for (int k = 0; k < 8; k++) e[14 + 8*k] = 1'b1;
    checks++; if (v_deser !== e) begin errors++; $display("FAIL clean_deser got=%h exp=%h", v_deser, e); end
    e = '0; e[80] = 1'b1;
    checks++; if (v_dv !== e) begin errors++; $display("FAIL clean_valid got=%h exp=%h", v_dv, e); end
    e = '0; e[6] = 1'b1;
    checks++; if (v_strt !== e) begin errors++; $display("FAIL clean_strt got=%h exp=%h", v_strt, e); end
    e = '0; e[78] = 1'b1;
    checks++; if (v_stp !== e) begin errors++; $display("FAIL clean_stp got=%h exp=%h", v_stp, e); end
    checks++; if (v_par !== '0) begin errors++; $display("FAIL clean_par got=%h exp=0", v_par); end
    checks++;
    if ({v_edge[0], v_edge[5], v_edge[8], v_edge[79]} !== {6'd0, 6'd5, 6'd0, 6'd7}) begin
      errors++; $display("FAIL clean_edge got=%0d,%0d,%0d,%0d exp=0,5,0,7", v_edge[0], v_edge[5], v_edge[8], v_edge[79]);
    end
    checks++;
    if ({v_samp[0], v_samp[1], v_samp[79], v_samp[80]} !== 4'b0110) begin
      errors++; $display("FAIL clean_samp_en got=%b exp=0110", {v_samp[0], v_samp[1], v_samp[79], v_samp[80]});
    end
  endtask

  task automatic test_parity();
    PAR_EN = 1'b1;
    run(96, {13'd0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 8, 0, -1, 1 << 30);
    e = '0; e[78] = 1'b1;
    checks++; if (v_par !== e) begin errors++; $display("FAIL par_chk got=%h exp=%h", v_par, e); end
    e = '0; e[86] = 1'b1;
    checks++; if (v_stp !== e) begin errors++; $display("FAIL par_stp got=%h exp=%h", v_stp, e); end
    e = '0; e[88] = 1'b1;
    checks++; if (v_dv !== e) begin errors++; $display("FAIL par_valid got=%h exp=%h", v_dv, e); end
    par_err = 1'b1;
    run(96, {13'd0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, 8, 0, -1, 1 << 30);
    checks++; if (v_dv !== '0) begin errors++; $display("FAIL par_err_drop got=%h exp=0", v_dv); end
`ifdef UART_RX_ERR_FLAGS_EN
    e = '0; e[88] = 1'b1;
    checks++; if (v_pef !== e) begin errors++; $display("FAIL par_err_flag got=%h exp=%h", v_pef, e); end
`endif
    PAR_EN = 1'b0;
    run(90, {14'd0, 1'b1, 8'hA5, 1'b0}, 10, 8, 0, -1, 1 << 30);
    e = '0; e[80] = 1'b1;
    checks++; if (v_dv !== e) begin errors++; $display("FAIL par_err_ignored got=%h exp=%h", v_dv, e); end
    par_err = 1'b0;
  endtask

  task automatic test_glitch();
    strt_glitch = 1'b1;
    run(40, 24'd0, 0, 8, 2, -1, 1 << 30);
    checks++;
    if ({v_samp[7], v_samp[8]} !== 2'b10) begin
      errors++; $display("FAIL glitch_idle got=%b exp=10", {v_samp[7], v_samp[8]});
    end
    checks++;
    if ((v_deser | v_dv) !== '0) begin errors++; $display("FAIL glitch_no_data got=%h exp=0", v_deser | v_dv); end
    strt_glitch = 1'b0;
  endtask

  task automatic test_stop_err();
    stp_err = 1'b1;
    run(90, {14'd0, 1'b0, 8'hA5, 1'b0}, 10, 8, 0, -1, 1 << 30);
    checks++; if (v_dv !== '0) begin errors++; $display("FAIL stop_err_drop got=%h exp=0", v_dv); end
    checks++;
    if ({v_samp[80], v_samp[81]} !== 2'b00) begin
      errors++; $display("FAIL stop_err_idle got=%b exp=00", {v_samp[80], v_samp[81]});
    end
`ifdef UART_RX_ERR_FLAGS_EN
    e = '0; e[80] = 1'b1;
    checks++; if (v_sef !== e) begin errors++; $display("FAIL stp_err_flag got=%h exp=%h", v_sef, e); end
`endif
    stp_err = 1'b0;
  endtask

  task automatic test_back_to_back();
    run(170, {4'd0, 1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0}, 20, 8, 0, -1, 1 << 30);
    e = '0; e[80] = 1'b1; e[160] = 1'b1;
    checks++; if (v_dv !== e) begin errors++; $display("FAIL b2b_valid got=%h exp=%h", v_dv, e); end
    e = '0; for (int k = 0; k < 8; k++) begin e[14 + 8*k] = 1'b1; e[94 + 8*k] = 1'b1; end
    checks++; if (v_deser !== e) begin errors++; $display("FAIL b2b_deser got=%h exp=%h", v_deser, e); end
    checks++;
    if ({v_samp[80], v_samp[81], v_edge[81]} !== {1'b0, 1'b1, 6'd1}) begin
      errors++; $display("FAIL b2b_restart got=%b,%b,%0d exp=0,1,1", v_samp[80], v_samp[81], v_edge[81]);
    end
  endtask

  task automatic test_prescale();
    run(170, {14'd0, 1'b1, 8'hA5, 1'b0}, 10, 16, 0, -1, 1 << 30);
    e = '0; for (int k = 0; k < 8; k++) e[26 + 16*k] = 1'b1;
    checks++; if (v_deser !== e) begin errors++; $display("FAIL p16_deser got=%h exp=%h", v_deser, e); end
    e = '0; e[160] = 1'b1;
    checks++; if (v_dv !== e) begin errors++; $display("FAIL p16_valid got=%h exp=%h", v_dv, e); end
    run(90, {14'd0, 1'b1, 8'hA5, 1'b0}, 10, 8, 0, 20, 1 << 30);
    e = '0; for (int k = 0; k < 8; k++) e[14 + 8*k] = 1'b1;
    checks++; if (v_deser !== e) begin errors++; $display("FAIL latch_deser got=%h exp=%h", v_deser, e); end
    e = '0; e[80] = 1'b1;
    checks++; if (v_dv !== e) begin errors++; $display("FAIL latch_valid got=%h exp=%h", v_dv, e); end
  endtask

  task automatic test_reset_mid();
    run(100, {14'd0, 1'b1, 8'hA5, 1'b0}, 10, 8, 0, -1, 30);
    e = '0; e[14] = 1'b1; e[22] = 1'b1;
    checks++; if (v_deser !== e) begin errors++; $display("FAIL rst_mid_deser got=%h exp=%h", v_deser, e); end
    e = '0; for (int t = 1; t < 30; t++) e[t] = 1'b1;
    checks++; if (v_samp !== e) begin errors++; $display("FAIL rst_mid_samp got=%h exp=%h", v_samp, e); end
    checks++;
    if ({v_edge[30], v_dv[79:0]} !== 86'd0) begin
      errors++; $display("FAIL rst_mid_zero edge=%0d dv=%h exp=0", v_edge[30], v_dv);
    end
    run(90, {14'd0, 1'b1, 8'h5A, 1'b0}, 10, 8, 0, -1, 1 << 30);
    e = '0; e[80] = 1'b1;
    checks++; if (v_dv !== e) begin errors++; $display("FAIL rst_mid_next got=%h exp=%h", v_dv, e); end
  endtask

  task automatic test_line_low();
    stp_err = 1'b1;
    run(170, 24'd0, 24, 8, 0, -1, 1 << 30);
    checks++; if (v_dv !== '0) begin errors++; $display("FAIL low_valid got=%h exp=0", v_dv); end
    checks++;
    if ({v_samp[80], v_samp[81], v_edge[81], v_deser[94]} !== {1'b0, 1'b1, 6'd1, 1'b1}) begin
      errors++; $display("FAIL low_restart got=%b,%b,%0d,%b exp=0,1,1,1", v_samp[80], v_samp[81], v_edge[81], v_deser[94]);
    end
    stp_err = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_parity();
    test_glitch();
    test_stop_err();
    test_back_to_back();
    test_prescale();
    test_reset_mid();
    test_line_low();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
